// File: rtl/sys_bridge_pkg.sv
// Shared types and constants for the CPU-to-peripheral bridge.
// The FSM encoding, common widths and a constant-width helper live here.
package sys_bridge_pkg;

    localparam int HWINT_W = 6;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2_f(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sys_bridge_n_irq_cond.sv
// Interrupt conditioning: level lines pass through a register, edge lines latch a
// rising edge until acknowledged. The pending register directly drives HWInt.
module irq_cond
    import sys_bridge_pkg::*;
#(
    parameter int                 N_IRQ    = 6,
    parameter logic [HWINT_W-1:0] IRQ_EDGE = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_IRQ-1:0]   irq_i,
    input  logic [N_IRQ-1:0]   ack_i,
    output logic [HWINT_W-1:0] hwint_o
);

    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] pend_q;
    logic [N_IRQ-1:0] pend_d;

    // A new edge beats a coincident acknowledge, so no interrupt is lost.
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
        assign pend_d[gi] = IRQ_EDGE[gi]
                          ? ((irq_i[gi] & ~prev_q[gi]) | (pend_q[gi] & ~ack_i[gi]))
                          : irq_i[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= irq_i;
            pend_q <= pend_d;
        end
    end

    assign hwint_o = HWINT_W'(pend_q);

endmodule

// File: rtl/sys_bridge_n.sv
// CPU-to-peripheral bridge: slot decode, one registered access at a time with
// request/acknowledge wait states and a timeout, plus interrupt conditioning.
module sys_bridge_n
    import sys_bridge_pkg::*;
#(
    parameter int                 N_DEV     = 3,
    parameter logic [31:0]        BASE_ADDR = 32'h0000_7F00,
    parameter int                 SLOT_BITS = 4,
    parameter int                 N_IRQ     = 6,
    parameter logic [HWINT_W-1:0] IRQ_EDGE  = 6'b000000,
    parameter int                 TIMEOUT   = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    PrReq,
    input  logic                    PrWe,
    input  logic [31:0]             PrAddr,
    input  logic [DATA_W-1:0]       PrWd,
    output logic [DATA_W-1:0]       PrRd,
    output logic                    PrReady,
    output logic                    PrErr,
    output logic [N_DEV-1:0]        DEV_Sel,
    output logic [N_DEV-1:0]        DEV_Wr,
    output logic [SLOT_BITS-3:0]    DEV_Addr,
    output logic [DATA_W-1:0]       DEV_Wd,
    input  logic [DATA_W*N_DEV-1:0] DEV_Rd,
    input  logic [N_DEV-1:0]        DEV_Ack,
    input  logic [N_IRQ-1:0]        DEV_IRQ,
    input  logic [N_IRQ-1:0]        IrqAck,
    output logic [HWINT_W-1:0]      HWInt
);

    localparam int TMR_W = clog2_f(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [N_DEV-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic [SLOT_BITS-3:0] addr_q, addr_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                err_q, err_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic [N_DEV-1:0]    hit;
    logic [DATA_W-1:0]   rd_mux;
    logic                ack_sel;
    logic                unused_addr_lsbs;

    assign unused_addr_lsbs = ^PrAddr[1:0];

    for (genvar gi = 0; gi < N_DEV; gi++) begin : g_dec
        localparam logic [31:0] SLOT_BASE = BASE_ADDR + (32'(gi) << SLOT_BITS);
        assign hit[gi] = (PrAddr[31:SLOT_BITS] == SLOT_BASE[31:SLOT_BITS]);
    end

    // Select is one-hot, so an OR of the gated lanes is the read mux.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (sel_q[i]) rd_mux = rd_mux | DEV_Rd[DATA_W*i +: DATA_W];
        end
    end

    assign ack_sel = |(DEV_Ack & sel_q);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        err_d   = err_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (PrReq) begin
                    if (|hit) begin
                        sel_d   = hit;
                        we_d    = PrWe;
                        addr_d  = PrAddr[SLOT_BITS-1:2];
                        wd_d    = PrWd;
                        timer_d = '0;
                        state_d = ST_ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rd_d    = '0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (ack_sel) begin
                    rd_d    = we_q ? '0 : rd_mux;
                    err_d   = 1'b0;
                    sel_d   = '0;
                    state_d = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    rd_d    = '0;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign PrReady  = (state_q == ST_RESP);
    assign PrRd     = rd_q;
    assign PrErr    = err_q;
    assign DEV_Sel  = sel_q;
    assign DEV_Wr   = sel_q & {N_DEV{we_q}};
    assign DEV_Addr = addr_q;
    assign DEV_Wd   = wd_q;

    irq_cond #(
        .N_IRQ    (N_IRQ),
        .IRQ_EDGE (IRQ_EDGE)
    ) u_irq_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_i   (DEV_IRQ),
        .ack_i   (IrqAck),
        .hwint_o (HWInt)
    );

endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed bench for sys_bridge_n: reads, writes, miss, timeout, interrupts and
// mid-access reset, each against hand-computed expected values.
module tb_sys_bridge_n;

    localparam int N_DEV = 3;
    localparam int N_IRQ = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         PrReq;
    logic         PrWe;
    logic [31:0]  PrAddr;
    logic [31:0]  PrWd;
    logic [31:0]  PrRd;
    logic         PrReady;
    logic         PrErr;
    logic [2:0]   DEV_Sel;
    logic [2:0]   DEV_Wr;
    logic [1:0]   DEV_Addr;
    logic [31:0]  DEV_Wd;
    logic [95:0]  DEV_Rd;
    logic [2:0]   DEV_Ack;
    logic [5:0]   DEV_IRQ;
    logic [5:0]   IrqAck;
    logic [5:0]   HWInt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sys_bridge_n #(
        .N_DEV     (N_DEV),
        .BASE_ADDR (32'h0000_7F00),
        .SLOT_BITS (4),
        .N_IRQ     (N_IRQ),
        .IRQ_EDGE  (6'b000010),
        .TIMEOUT   (15)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PrReq    (PrReq),
        .PrWe     (PrWe),
        .PrAddr   (PrAddr),
        .PrWd     (PrWd),
        .PrRd     (PrRd),
        .PrReady  (PrReady),
        .PrErr    (PrErr),
        .DEV_Sel  (DEV_Sel),
        .DEV_Wr   (DEV_Wr),
        .DEV_Addr (DEV_Addr),
        .DEV_Wd   (DEV_Wd),
        .DEV_Rd   (DEV_Rd),
        .DEV_Ack  (DEV_Ack),
        .DEV_IRQ  (DEV_IRQ),
        .IrqAck   (IrqAck),
        .HWInt    (HWInt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request presented in cycle 0; returns at the start of cycle 1.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        PrReq  = 1'b1;
        PrWe   = we;
        PrAddr = addr;
        PrWd   = wd;
        tick();
        PrReq  = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        PrReq   = 1'b0;
        PrWe    = 1'b0;
        PrAddr  = '0;
        PrWd    = '0;
        DEV_Rd  = '0;
        DEV_Ack = '0;
        DEV_IRQ = '0;
        IrqAck  = '0;
        #12;
        chk("rst_ready", 32'(PrReady), 32'h0);
        chk("rst_err",   32'(PrErr),   32'h0);
        chk("rst_rd",    PrRd,         32'h0);
        chk("rst_sel",   32'(DEV_Sel), 32'h0);
        chk("rst_hwint", 32'(HWInt),   32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Read slot 1 with three wait states; stray ack on dev0 must be ignored.
        DEV_Rd[63:32] = 32'hDEAD_BEEF;
        issue(1'b0, 32'h0000_7F14, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            chk("rd1_sel",     32'(DEV_Sel), 32'h2);
            chk("rd1_rdy_low", 32'(PrReady), 32'h0);
            DEV_Ack = (c == 2) ? 3'b001 : ((c == 4) ? 3'b010 : 3'b000);
            tick();
        end
        DEV_Ack = '0;
        chk("rd1_ready", 32'(PrReady), 32'h1);
        chk("rd1_data",  PrRd,         32'hDEAD_BEEF);
        chk("rd1_err",   32'(PrErr),   32'h0);
        chk("rd1_sel0",  32'(DEV_Sel), 32'h0);
        $display("txn read  0x00007f14 rd=0x%08h err=%0d", PrRd, PrErr);
        tick();
        chk("rd1_pulse", 32'(PrReady), 32'h0);

        // Miss: answers next cycle with error and zero data.
        issue(1'b0, 32'h0000_7F40, 32'h0);
        chk("miss_ready", 32'(PrReady), 32'h1);
        chk("miss_err",   32'(PrErr),   32'h1);
        chk("miss_rd",    PrRd,         32'h0);
        chk("miss_sel",   32'(DEV_Sel), 32'h0);
        $display("txn read  0x00007f40 rd=0x%08h err=%0d", PrRd, PrErr);
        tick();

        // Write slot 0 word 2, immediate ack.
        issue(1'b1, 32'h0000_7F08, 32'h0000_0012);
        chk("wr_wr",   32'(DEV_Wr),   32'h1);
        chk("wr_sel",  32'(DEV_Sel),  32'h1);
        chk("wr_addr", 32'(DEV_Addr), 32'h2);
        chk("wr_wd",   DEV_Wd,        32'h12);
        DEV_Ack = 3'b001;
        tick();
        DEV_Ack = '0;
        chk("wr_ready", 32'(PrReady), 32'h1);
        chk("wr_err",   32'(PrErr),   32'h0);
        chk("wr_rd",    PrRd,         32'h0);
        chk("wr_wr0",   32'(DEV_Wr),  32'h0);
        $display("txn write 0x00007f08 wd=0x00000012 err=%0d", PrErr);
        tick();

        // Timeout on slot 2; a PrReq mid-access must be ignored.
        issue(1'b0, 32'h0000_7F20, 32'h0);
        for (int c = 1; c <= 15; c++) begin
            chk("to_rdy_low", 32'(PrReady), 32'h0);
            chk("to_sel",     32'(DEV_Sel), 32'h4);
            PrReq  = (c == 5);
            PrAddr = 32'h0000_7F40;
            tick();
        end
        PrReq = 1'b0;
        chk("to_ready", 32'(PrReady), 32'h1);
        chk("to_err",   32'(PrErr),   32'h1);
        chk("to_rd",    PrRd,         32'h0);
        $display("txn read  0x00007f20 rd=0x%08h err=%0d (timeout)", PrRd, PrErr);
        tick();
        chk("to_idle", 32'(PrReady), 32'h0);

        // Ack in the very cycle the timer expires: ack wins.
        DEV_Rd[95:64] = 32'hCAFE_0002;
        issue(1'b0, 32'h0000_7F24, 32'h0);
        for (int c = 1; c <= 15; c++) begin
            chk("tw_rdy_low", 32'(PrReady), 32'h0);
            DEV_Ack = (c == 15) ? 3'b100 : 3'b000;
            tick();
        end
        DEV_Ack = '0;
        chk("tw_ready", 32'(PrReady), 32'h1);
        chk("tw_err",   32'(PrErr),   32'h0);
        chk("tw_rd",    PrRd,         32'hCAFE_0002);
        $display("txn read  0x00007f24 rd=0x%08h err=%0d (late ack)", PrRd, PrErr);
        tick();

        // Edge line 1: pulse latches until acked.
        DEV_IRQ = 6'b000010;
        tick();
        DEV_IRQ = '0;
        chk("irq_edge_set",  32'(HWInt), 32'h02);
        tick();
        chk("irq_edge_hold", 32'(HWInt), 32'h02);
        IrqAck = 6'b000010;
        tick();
        IrqAck = '0;
        chk("irq_edge_clr", 32'(HWInt), 32'h00);
        // Re-pend, then ack together with a fresh edge: set wins.
        DEV_IRQ = 6'b000010;
        tick();
        DEV_IRQ = '0;
        chk("irq_edge_set2", 32'(HWInt), 32'h02);
        tick();
        DEV_IRQ = 6'b000010;
        IrqAck  = 6'b000010;
        tick();
        DEV_IRQ = '0;
        chk("irq_set_wins", 32'(HWInt), 32'h02);
        tick();
        IrqAck = '0;
        chk("irq_ack_clr", 32'(HWInt), 32'h00);
        // Held-high edge line: ack clears and no re-set without a new edge.
        DEV_IRQ = 6'b000010;
        tick();
        chk("irq_held_set", 32'(HWInt), 32'h02);
        IrqAck = 6'b000010;
        tick();
        IrqAck = '0;
        chk("irq_held_clr", 32'(HWInt), 32'h00);
        tick();
        chk("irq_held_stay", 32'(HWInt), 32'h00);
        DEV_IRQ = '0;
        // Level line 0 follows with one cycle lag; IrqAck has no effect.
        DEV_IRQ = 6'b000001;
        IrqAck  = 6'b000001;
        tick();
        DEV_IRQ = '0;
        IrqAck  = '0;
        chk("irq_level_on", 32'(HWInt), 32'h01);
        tick();
        chk("irq_level_off", 32'(HWInt), 32'h00);
        $display("txn irq sequence done hwint=0x%02h", HWInt);

        // Reset in the middle of an access.
        DEV_IRQ = 6'b000001;
        issue(1'b1, 32'h0000_7F0C, 32'h5555_AAAA);
        chk("rs_pre_sel",   32'(DEV_Sel), 32'h1);
        chk("rs_pre_hwint", 32'(HWInt),   32'h01);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rs_sel",   32'(DEV_Sel),  32'h0);
        chk("rs_wr",    32'(DEV_Wr),   32'h0);
        chk("rs_wd",    DEV_Wd,        32'h0);
        chk("rs_addr",  32'(DEV_Addr), 32'h0);
        chk("rs_ready", 32'(PrReady),  32'h0);
        chk("rs_hwint", 32'(HWInt),    32'h0);
        DEV_IRQ = '0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("rs_no_ready", 32'(PrReady), 32'h0);
            chk("rs_idle_sel", 32'(DEV_Sel), 32'h0);
            tick();
        end
        $display("txn reset during access");

        // Next access after reset is served normally.
        DEV_Rd[31:0] = 32'h0BAD_F00D;
        issue(1'b0, 32'h0000_7F04, 32'h0);
        chk("pr_sel",  32'(DEV_Sel),  32'h1);
        chk("pr_addr", 32'(DEV_Addr), 32'h1);
        DEV_Ack = 3'b001;
        tick();
        DEV_Ack = '0;
        chk("pr_ready", 32'(PrReady), 32'h1);
        chk("pr_rd",    PrRd,         32'h0BAD_F00D);
        chk("pr_err",   32'(PrErr),   32'h0);
        $display("txn read  0x00007f04 rd=0x%08h err=%0d", PrRd, PrErr);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
